// File: rtl/fmul_pack.sv
// Final pack stage of the single-precision multiplier: classifies the biased exponent,
// assembles the IEEE-754 word and keeps sticky overflow/underflow flags.
module fmul_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x3,
  input  logic [8:0]  base_ei,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clr_flags,
  output logic        sticky_ovf,
  output logic        sticky_unf
);

  typedef enum logic [1:0] {CL_NORM, CL_OVF, CL_UNF, CL_ZERO} cls_t;

  typedef struct packed {
    logic        sign;
    cls_t        cls;
    logic [7:0]  exp;
    logic [22:0] frac;
  } s1_t;

  logic [2:1]  vld_pipe;
  s1_t         s1_d, s1_q;
  logic        s1_adv, s2_adv, out_xfer;
  logic [31:0] res_d;
  logic        unused_bits;

  assign unused_bits = ^x3[30:24];

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];
  assign out_xfer  = vld_pipe[2] && out_ready;

  // Zero significand wins over any exponent; 384..511 is a wrapped negative exponent.
  always_comb begin
    s1_d.sign = x3[31];
    s1_d.exp  = base_ei[7:0];
    s1_d.frac = x3[22:0];
    if (!x3[23])                             s1_d.cls = CL_ZERO;
    else if (base_ei == 9'd0 || base_ei >= 9'd384) s1_d.cls = CL_UNF;
    else if (base_ei >= 9'd255)              s1_d.cls = CL_OVF;
    else                                     s1_d.cls = CL_NORM;
  end

  always_comb begin
    res_d = {s1_q.sign, 31'h0};
    unique case (s1_q.cls)
      CL_NORM: res_d = {s1_q.sign, s1_q.exp, s1_q.frac};
      CL_OVF:  res_d = {s1_q.sign, 8'hFF, 23'h0};
      default: res_d = {s1_q.sign, 31'h0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          result <= res_d;
          ovf    <= (s1_q.cls == CL_OVF);
          unf    <= (s1_q.cls == CL_UNF);
        end
      end
      // A setting transfer overrides a simultaneous clear.
      sticky_ovf <= (sticky_ovf && !clr_flags) || (out_xfer && ovf);
      sticky_unf <= (sticky_unf && !clr_flags) || (out_xfer && unf);
    end
  end

endmodule

// File: doc/fmul_pack.md
# fmul_pack

Final stage of the single-precision multiplier pipeline. It consumes the normalized `{sign, significand32}` word and the 9-bit base exponent produced by the normalization stage. It classifies the exponent into normal, overflow or underflow, handles zero significands, and assembles an IEEE-754 single-precision result. It is a 2-stage pipeline with valid/ready backpressure on both sides and sticky exception flags for the FPU status register.

## Interface
- No parameters.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `x3` input 32: bit 31 is the sign. Bits [30:24] must be 0. Bit 23 is the hidden bit. Bits [22:0] are the fraction.
- `base_ei` input 9: biased exponent of the normalized significand (encoding defined under Operation).
- `in_valid` input 1: `x3` and `base_ei` are valid this cycle.
- `in_ready` output 1: the block accepts the input this cycle.
- `result` output 32: IEEE-754 single-precision result.
- `ovf` output 1: `result` is a signed infinity caused by exponent overflow.
- `unf` output 1: `result` is a signed zero caused by exponent underflow (flush-to-zero).
- `out_valid` output 1: `result`, `ovf` and `unf` are valid.
- `out_ready` input 1: the downstream block takes the output this cycle.
- `clr_flags` input 1: clears the sticky flags.
- `sticky_ovf` output 1: set by any delivered overflow result.
- `sticky_unf` output 1: set by any delivered underflow result.

## Operation
Inputs are accepted when `in_valid && in_ready`. A "transfer" is that handshake on the input or output side.

Exponent classification, with `base_ei` read as unsigned 0..511, is done in stage 1:
- Zero case: `x3[23]==0` means the operand is zero. The output is `{x3[31], 31'h0}` with `ovf=0` and `unf=0`, regardless of exponent.
- 1..254 is normal. The output is `{x3[31], base_ei[7:0], x3[22:0]}`.
- 255..383 is overflow. The output is `{x3[31], 8'hFF, 23'h0}` with `ovf=1`.
- 0 and 384..511 are underflow; 384..511 is the negative-wrap range. The output is `{x3[31], 31'h0}` with `unf=1`. There are no denormals.
- Bits [30:24] of `x3` are ignored.

Stage 1 registers the following, and stage 2 assembles `result` and registers it with `ovf` and `unf`:
- sign;
- class (2 bits: normal, overflow, underflow, zero);
- `exp[7:0]`;
- fraction.

Pipeline control:
- Each stage has a valid bit. `s2_adv = !s2_valid || out_ready`. `s1_adv = !s1_valid || s2_adv`. `in_ready = s1_adv`, which is combinational from `out_ready`.
- Stage registers load only when their stage advances. Otherwise they hold their value, so no data is lost under backpressure.
- While `out_valid && !out_ready`, `result`, `ovf` and `unf` must stay stable.

Sticky flags:
- An output transfer with `ovf=1` sets `sticky_ovf`. An output transfer with `unf=1` sets `sticky_unf`.
- `clr_flags` clears both. If `clr_flags` and a setting transfer occur in the same cycle, set wins.

Reset:
- All valid bits, `result`, `ovf`, `unf`, `sticky_ovf` and `sticky_unf` go to 0.
- `in_ready` reads 1 in the first cycle after reset.
- A reset during a stall discards in-flight data. No output transfer occurs in the reset cycle.

## Timing
- Latency is 2 cycles. An input accepted at edge N makes `out_valid=1` after edge N+1, and the output can be consumed at edge N+2.
- Throughput is one result per cycle while `out_ready=1`.
- With `out_ready=0`, at most 2 items are held. After that `in_ready=0` until `out_ready` returns.
- Simultaneous input and output transfers on a full pipe are legal and keep it full.
- The flags update on the edge of the output transfer and are visible the next cycle.

## Test plan
- Normal case:
  - Stimulus: `x3=32'h00C00000`, `base_ei=9'd128`, `out_ready=1`.
  - Required response: `result=32'h40400000` (3.0) two cycles later, with `ovf=0` and `unf=0`.
- Overflow and underflow:
  - Stimulus: `x3=32'h80800000` with `base_ei=9'd300`.
  - Required response: `result=32'hFF800000`, `ovf=1`, and `sticky_ovf=1` afterwards.
  - Stimulus: then `base_ei=9'd450`, and separately `base_ei=9'd0`.
  - Required response: `result=32'h80000000` with `unf=1` for both.
- Zero operand:
  - Stimulus: `x3=32'h80000000` with `base_ei=9'd300`.
  - Required response: `result=32'h80000000` with `ovf=0` and `unf=0`.
- Backpressure:
  - Stimulus: stream 4 normal inputs with `out_ready` held at 0.
  - Required response: exactly 2 are accepted and `in_ready=0` from the third. `result` stays stable.
  - Stimulus: then raise `out_ready`.
  - Required response: all 4 results emerge in order, with no loss or duplication.
- Sticky flags:
  - Stimulus: assert `clr_flags` in the same cycle as an overflow output transfer.
  - Required response: `sticky_ovf=1`.
  - Stimulus: assert `clr_flags` in a later idle cycle.
  - Required response: `sticky_ovf=0`.
- Reset mid-stall:
  - Stimulus: fill the pipe with `out_ready=0`, then pulse `rst`.
  - Required response: `out_valid=0`, `result=0`, flags 0, and `in_ready=1` the next cycle.
